// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the default widths, the FSM state encodings and the watchdog width helper.
package instr_fetch_pkg;

    localparam int unsigned IF_ADDR_W  = 15;
    localparam int unsigned IF_DATA_W  = 16;
    localparam int unsigned IF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    // Counter must hold TIMEOUT itself; a zero timeout still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_wdog.sv
// Watchdog for the fetch stage: loadable saturating counter with clear and enable.
// expire flags that the next enabled tick would reach TIMEOUT.
module fetch_wdog
    import instr_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = IF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             load,
    input  logic [cnt_width(TIMEOUT)-1:0]    load_val,
    input  logic                             en,
    output logic                             expire
);

    localparam int unsigned CntW = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] Limit    = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] LastTick = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == LastTick);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples the PC, runs a req/ack memory read, holds the word
// in the instruction register for decode and pulses pc_inc once per completed fetch.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = IF_ADDR_W,
    parameter int unsigned DATA_W  = IF_DATA_W,
    parameter int unsigned TIMEOUT = IF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              dec_ready,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pc_inc_q, pc_inc_d;
    logic              fetch_err_q, fetch_err_d;

    logic wd_clr, wd_load, wd_en, wd_expire;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wd_clr),
        .load     (wd_load),
        .load_val ('0),
        .en       (wd_en),
        .expire   (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        pc_inc_d    = 1'b0;
        fetch_err_d = 1'b0;
        wd_clr      = 1'b0;
        wd_load     = 1'b0;
        wd_en       = 1'b0;

        if (flush) begin
            // Flush overrides everything, including an ack landing this cycle.
            ir_valid_d = 1'b0;
            mem_req_d  = 1'b0;
            wd_clr     = 1'b1;
            state_d    = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_en) begin
                        mem_addr_d = pc_addr;
                        mem_req_d  = 1'b1;
                        wd_load    = 1'b1;
                        state_d    = StWait;
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        ir_d       = mem_rdata;
                        ir_valid_d = 1'b1;
                        mem_req_d  = 1'b0;
                        pc_inc_d   = 1'b1;
                        wd_clr     = 1'b1;
                        state_d    = StHold;
                    end else if (wd_expire) begin
                        mem_req_d   = 1'b0;
                        fetch_err_d = 1'b1;
                        wd_clr      = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        wd_en = 1'b1;
                    end
                end
                StHold: begin
                    if (dec_ready) begin
                        ir_valid_d = 1'b0;
                        // Back-to-back issue; pc_addr has already advanced by now.
                        if (fetch_en) begin
                            mem_addr_d = pc_addr;
                            mem_req_d  = 1'b1;
                            wd_load    = 1'b1;
                            state_d    = StWait;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    mem_req_d  = 1'b0;
                    ir_valid_d = 1'b0;
                    wd_clr     = 1'b1;
                    state_d    = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            pc_inc_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            pc_inc_q    <= pc_inc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ir_out    = ir_q;
    assign ir_valid  = ir_valid_q;
    assign pc_inc    = pc_inc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected fetch addresses and
// instruction words, with one task per scenario.
module tb_instr_fetch;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_en;
    logic              flush;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_inc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] ir_out;
    logic              ir_valid;
    logic              dec_ready;
    logic              fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .pc_addr   (pc_addr),
        .pc_inc    (pc_inc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .dec_ready (dec_ready),
        .fetch_err (fetch_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_ir_q[$];
    logic [DATA_W-1:0] last_ir;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] ea;
        int                seen;
        rst_n = 1'b0; fetch_en = 1'b0; flush = 1'b0; pc_addr = '0;
        mem_rdata = '0; mem_ack = 1'b0; dec_ready = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({mem_req, mem_addr, ir_out, ir_valid, pc_inc, fetch_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b addr=%h ir=%h v=%b inc=%b err=%b, want all 0",
                     mem_req, mem_addr, ir_out, ir_valid, pc_inc, fetch_err);
        end
        rst_n = 1'b1;
        fetch_en = 1'b1; pc_addr = 15'h0100; exp_addr_q.push_back(15'h0100);
        step();
        fetch_en = 1'b0;
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== ea) begin
            n_err++;
            $display("FAIL reset_pre_wait: got req=%b addr=%h, want req=1 addr=%h",
                     mem_req, mem_addr, ea);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mem_req, mem_addr, ir_out, ir_valid, pc_inc, fetch_err} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_wait: got req=%b addr=%h ir=%h v=%b inc=%b err=%b, want all 0",
                     mem_req, mem_addr, ir_out, ir_valid, pc_inc, fetch_err);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            step();
            if (pc_inc || mem_req || ir_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_release_quiet: got %0d active cycles, want 0", seen);
        end
        last_ir = '0;
    endtask

    task automatic test_basic_fetch();
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ei;
        int                incs;
        pc_addr = 15'h0010; fetch_en = 1'b1; exp_addr_q.push_back(15'h0010);
        step();
        fetch_en = 1'b0;
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== ea) begin
            n_err++;
            $display("FAIL basic_req: got req=%b addr=%h, want req=1 addr=%h", mem_req, mem_addr, ea);
        end
        mem_ack = 1'b1; mem_rdata = 16'hA5C3; exp_ir_q.push_back(16'hA5C3);
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        ei = exp_ir_q.pop_front();
        n_vec++;
        if (ir_valid !== 1'b1 || ir_out !== ei || mem_req !== 1'b0 || pc_inc !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ir: got v=%b ir=%h req=%b inc=%b, want v=1 ir=%h req=0 inc=1",
                     ir_valid, ir_out, mem_req, pc_inc, ei);
        end
        last_ir = ei;
        incs = 1;
        repeat (3) begin
            step();
            if (pc_inc) incs++;
        end
        n_vec++;
        if (incs != 1) begin
            n_err++;
            $display("FAIL basic_pc_inc_count: got %0d pulses, want 1", incs);
        end
    endtask

    task automatic test_hold_stall();
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ei;
        int                bad;
        fetch_en = 1'b1; dec_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            step();
            if (ir_valid !== 1'b1 || ir_out !== last_ir || mem_req !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: got %0d unstable cycles, want 0 (ir=%h want %h)",
                     bad, ir_out, last_ir);
        end
        pc_addr = 15'h0011; dec_ready = 1'b1; exp_addr_q.push_back(15'h0011);
        step();
        dec_ready = 1'b0; fetch_en = 1'b0;
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== ea || ir_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_next_req: got req=%b addr=%h v=%b, want req=1 addr=%h v=0",
                     mem_req, mem_addr, ir_valid, ea);
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234; exp_ir_q.push_back(16'h1234);
        step();
        mem_ack = 1'b0;
        ei = exp_ir_q.pop_front();
        n_vec++;
        if (ir_valid !== 1'b1 || ir_out !== ei) begin
            n_err++;
            $display("FAIL hold_second_ir: got v=%b ir=%h, want v=1 ir=%h", ir_valid, ir_out, ei);
        end
        last_ir = ei;
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        n_vec++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL hold_consume_idle: got v=%b req=%b, want v=0 req=0", ir_valid, mem_req);
        end
    endtask

    task automatic test_timeout();
        logic [ADDR_W-1:0] ea;
        int                req_cycles, err_at, err_cnt, incs;
        pc_addr = 15'h0020; fetch_en = 1'b1; exp_addr_q.push_back(15'h0020);
        step();
        fetch_en = 1'b0;
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== ea) begin
            n_err++;
            $display("FAIL timeout_req: got req=%b addr=%h, want req=1 addr=%h", mem_req, mem_addr, ea);
        end
        req_cycles = 1; err_at = 0; err_cnt = 0; incs = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (mem_req) req_cycles++;
            if (fetch_err) begin
                err_cnt++;
                if (err_at == 0) err_at = i;
            end
            if (pc_inc) incs++;
        end
        n_vec++;
        if (err_at != TIMEOUT || err_cnt != 1) begin
            n_err++;
            $display("FAIL timeout_err_pulse: got at=%0d count=%0d, want at=%0d count=1",
                     err_at, err_cnt, TIMEOUT);
        end
        n_vec++;
        if (req_cycles != TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_req_cycles: got %0d, want %0d", req_cycles, TIMEOUT);
        end
        n_vec++;
        if (incs != 0 || ir_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_no_inc: got inc=%0d v=%b, want inc=0 v=0", incs, ir_valid);
        end
    endtask

    task automatic test_flush_ack();
        logic [ADDR_W-1:0] ea;
        pc_addr = 15'h0030; fetch_en = 1'b1; exp_addr_q.push_back(15'h0030);
        step();
        fetch_en = 1'b0;
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== ea) begin
            n_err++;
            $display("FAIL flush_req: got req=%b addr=%h, want req=1 addr=%h", mem_req, mem_addr, ea);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD; flush = 1'b1;
        step();
        mem_ack = 1'b0; flush = 1'b0;
        n_vec++;
        if (ir_valid !== 1'b0 || ir_out !== last_ir || pc_inc !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ack: got v=%b ir=%h inc=%b req=%b, want v=0 ir=%h inc=0 req=0",
                     ir_valid, ir_out, pc_inc, mem_req, last_ir);
        end
        step();
        n_vec++;
        if (pc_inc !== 1'b0 || ir_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: got inc=%b v=%b, want inc=0 v=0", pc_inc, ir_valid);
        end
    endtask

    // Zero-wait memory, always-ready decode, PC model advancing on pc_inc with 15-bit wrap.
    task automatic test_back_to_back();
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ei;
        logic              was_ack;
        int                reqs, consumed, incs, first_v, cyc;
        pc_addr = 15'h7FFF;
        exp_addr_q.push_back(15'h7FFF);
        exp_addr_q.push_back(15'h0000);
        fetch_en = 1'b1; dec_ready = 1'b1;
        reqs = 0; consumed = 0; incs = 0; first_v = -1; cyc = 0;
        while (consumed < 2 && cyc < 40) begin
            step();
            cyc++;
            was_ack = mem_ack;
            mem_ack = 1'b0;
            if (pc_inc) begin
                incs++;
                pc_addr = pc_addr + 15'd1;
            end
            if (mem_req && !was_ack) begin
                reqs++;
                if (reqs >= 2) fetch_en = 1'b0;
                ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 15'h5555;
                n_vec++;
                if (mem_addr !== ea) begin
                    n_err++;
                    $display("FAIL b2b_addr%0d: got %h, want %h", reqs, mem_addr, ea);
                end
                mem_ack = 1'b1;
                mem_rdata = {1'b1, ea} ^ 16'h0F0F;
                exp_ir_q.push_back({1'b1, ea} ^ 16'h0F0F);
            end
            if (ir_valid) begin
                consumed++;
                if (first_v < 0) first_v = cyc;
                ei = (exp_ir_q.size() != 0) ? exp_ir_q.pop_front() : 16'hFFFF;
                n_vec++;
                if (ir_out !== ei) begin
                    n_err++;
                    $display("FAIL b2b_ir%0d: got %h, want %h", consumed, ir_out, ei);
                end
                if (consumed == 2) begin
                    n_vec++;
                    if (cyc - first_v != 2) begin
                        n_err++;
                        $display("FAIL b2b_throughput: got %0d cycles apart, want 2", cyc - first_v);
                    end
                end
            end
        end
        step();
        if (pc_inc) incs++;
        fetch_en = 1'b0; dec_ready = 1'b0;
        n_vec++;
        if (consumed != 2) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d instructions in %0d cycles, want 2", consumed, cyc);
        end
        n_vec++;
        if (incs != 2 || pc_addr !== 15'h0001) begin
            n_err++;
            $display("FAIL b2b_pc_inc: got %0d pulses pc=%h, want 2 pulses pc=0001", incs, pc_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_timeout();
        test_flush_ack();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
